tri_lcb_gate_ctl: RTL
=====================

TRI_LCB_GATE_CTL -- requirements
Module: tri_lcb_gate_ctl

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 2, giving the number of cycles lclk_sreset is asserted per init sequence (legal 1..15).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 1, giving the number of cycles d2clk stays high after thold rises before hold is entered (legal 0..15).
REQ-003 SHALL have parameter HYST_CYCLES, default 3, giving the number of extra cycles d1clk stays high after act_req falls (legal 1..15).
REQ-004 SHALL have port nclk, input, 1 bit: the single block clock; all state changes on its rising edge.
REQ-005 SHALL have port sreset_b, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port act_req, input, 1 bit: functional update request for the downstream latch bank.
REQ-007 SHALL have port force_act, input, 1 bit: forces d1clk high in RUN regardless of act_req.
REQ-008 SHALL have port thold, input, 1 bit: clock-hold request.
REQ-009 SHALL have port init_req, input, 1 bit: request to rerun the init (sreset) sequence.
REQ-010 SHALL have port d1clk, output, 1 bit: latch-enable (act) to the downstream latch bank.
REQ-011 SHALL have port d2clk, output, 1 bit: thold_b to the downstream latch bank (0 = hold).
REQ-012 SHALL have port lclk_sreset, output, 1 bit: drives lclk[1] (sreset) of the downstream latch bank.
REQ-013 SHALL have port hold_ack, output, 1 bit: high while in HOLD.
REQ-014 SHALL have port init_done, output, 1 bit: single-cycle pulse on the first RUN cycle after INIT.

Function
REQ-015 SHALL implement states IDLE, INIT, RUN, DRAIN and HOLD; all outputs are registered and reflect the state entered at the preceding edge.
REQ-016 Transitions SHALL be: IDLE->INIT at the first edge with sreset_b=1; INIT->RUN after INIT_CYCLES cycles; RUN->INIT on init_req; RUN->DRAIN on thold (direct to HOLD if DRAIN_CYCLES=0); DRAIN->HOLD after DRAIN_CYCLES cycles with thold still high; DRAIN->RUN if thold drops; HOLD->RUN on thold=0; HOLD->INIT on init_req.
REQ-017 Priority SHALL be init_req over thold when both are high in RUN or HOLD.
REQ-018 init_req SHALL be ignored in IDLE, INIT and DRAIN.
REQ-019 Outputs per state SHALL be: IDLE all 0; INIT d1clk=1, d2clk=1, lclk_sreset=1; RUN d2clk=1, lclk_sreset=0, d1clk per REQ-020; DRAIN same as RUN; HOLD d1clk=0, d2clk=0, hold_ack=1.
REQ-020 In RUN/DRAIN, d1clk SHALL be the registered value of force_act | act_req | (hyst_cnt!=0).
REQ-021 hyst_cnt SHALL load HYST_CYCLES on an edge with act_req=1, otherwise decrement to a floor of 0, and clear on entry to HOLD or INIT.
REQ-022 Counters SHALL be 4 bits wide and never wrap below 0.
REQ-023 init_done SHALL pulse for exactly one cycle on every INIT->RUN transition and on no other transition.

Reset
REQ-024 sreset_b=0 at an edge SHALL force state IDLE, clear all counters and force all outputs to 0, including mid-INIT and mid-DRAIN.
REQ-025 Reset SHALL have no asynchronous effect.

Configuration
REQ-026 Macro TRI_LCB_ACT_HYST_EN SHALL gate the hysteresis counter: when defined, REQ-020/021 apply; when undefined, d1clk in RUN/DRAIN is the registered value of force_act | act_req, HYST_CYCLES is ignored, and no counter is built.

Verification
REQ-027 Reset release -> lclk_sreset=1 for exactly 2 cycles, then init_done=1 for 1 cycle, then RUN with d2clk=1.
REQ-028 With the macro defined and HYST_CYCLES=3, act_req high for 5 edges then low -> d1clk high for 8 consecutive cycles; with the macro undefined -> 5 cycles.
REQ-029 thold high in RUN with DRAIN_CYCLES=1 -> d2clk=1 for 1 more cycle, then d2clk=0 and hold_ack=1; thold low -> RUN on the next cycle.
REQ-030 thold and init_req high together in RUN -> INIT (lclk_sreset=1 for 2 cycles), no hold_ack.
REQ-031 sreset_b low for 1 cycle during INIT -> all outputs 0 next cycle, then a full fresh 2-cycle INIT sequence.

Source files
------------

// File: rtl/tri_lcb_gate_ctl.sv
// tri_lcb_gate_ctl: local clock buffer gate controller (init/run/drain/hold).
// Optional act hysteresis counter built only when TRI_LCB_ACT_HYST_EN is defined.
//
// Ports:
//   nclk        block clock, all state changes on rising edge
//   sreset_b    synchronous active-low reset
//   act_req     functional update request for the latch bank
//   force_act   forces d1clk high in RUN/DRAIN
//   thold       clock-hold request
//   init_req    rerun the sreset init sequence
//   d1clk       latch enable (act) to the latch bank
//   d2clk       thold_b to the latch bank (0 = hold)
//   lclk_sreset sreset leg of the latch bank lclk
//   hold_ack    high while holding
//   init_done   one-cycle pulse on the first RUN cycle after INIT
module tri_lcb_gate_ctl #(
  parameter int INIT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 1,
  parameter int HYST_CYCLES  = 3
) (
  input  logic nclk,
  input  logic sreset_b,
  input  logic act_req,
  input  logic force_act,
  input  logic thold,
  input  logic init_req,
  output logic d1clk,
  output logic d2clk,
  output logic lclk_sreset,
  output logic hold_ack,
  output logic init_done
);

  if (INIT_CYCLES < 1 || INIT_CYCLES > 15 ||
      DRAIN_CYCLES < 0 || DRAIN_CYCLES > 15 ||
      HYST_CYCLES < 1 || HYST_CYCLES > 15) begin : g_bad_params
    $error("tri_lcb_gate_ctl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_HOLD
  } state_e;

  localparam logic [3:0] INIT_LD  = 4'(INIT_CYCLES - 1);
  // With no drain phase the count is never used.
  localparam logic [3:0] DRAIN_LD =
    (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       d1_q, d1_d;
  logic       d2_q, d2_d;
  logic       sr_q, sr_d;
  logic       hk_q, hk_d;
  logic       dn_q, dn_d;
  logic       act_w;
  logic       init_entry;

  assign init_entry = (state_d == S_INIT) && (state_q != S_INIT);

`ifdef TRI_LCB_ACT_HYST_EN
  localparam logic [3:0] HYST_LD = 4'(HYST_CYCLES);

  logic [3:0] hyst_cnt_q, hyst_cnt_d;

  always_comb begin
    hyst_cnt_d = hyst_cnt_q;
    if (act_req) begin
      hyst_cnt_d = HYST_LD;
    end else if (hyst_cnt_q != 4'd0) begin
      hyst_cnt_d = hyst_cnt_q - 4'd1;
    end
    if (init_entry || (state_d == S_HOLD && state_q != S_HOLD)) begin
      hyst_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge nclk) begin
    if (!sreset_b) hyst_cnt_q <= 4'd0;
    else           hyst_cnt_q <= hyst_cnt_d;
  end

  assign act_w = force_act | act_req | (hyst_cnt_q != 4'd0);
`else
  assign act_w = force_act | act_req;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_INIT;
      S_INIT:  if (init_cnt_q == 4'd0) state_d = S_RUN;
      S_RUN: begin
        if (init_req)   state_d = S_INIT;
        else if (thold) state_d = (DRAIN_CYCLES == 0) ? S_HOLD : S_DRAIN;
      end
      S_DRAIN: begin
        if (!thold)                    state_d = S_RUN;
        else if (drain_cnt_q == 4'd0)  state_d = S_HOLD;
      end
      S_HOLD: begin
        if (init_req)    state_d = S_INIT;
        else if (!thold) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    init_cnt_d = init_cnt_q;
    if (init_entry) begin
      init_cnt_d = INIT_LD;
    end else if (state_q == S_INIT && init_cnt_q != 4'd0) begin
      init_cnt_d = init_cnt_q - 4'd1;
    end
    drain_cnt_d = drain_cnt_q;
    if (state_d == S_DRAIN && state_q != S_DRAIN) begin
      drain_cnt_d = DRAIN_LD;
    end else if (state_q == S_DRAIN && drain_cnt_q != 4'd0) begin
      drain_cnt_d = drain_cnt_q - 4'd1;
    end
  end

  // Outputs are decoded from the state being entered so they are registered.
  always_comb begin
    d1_d = 1'b0;
    d2_d = 1'b0;
    sr_d = 1'b0;
    hk_d = 1'b0;
    dn_d = (state_q == S_INIT) && (state_d == S_RUN);
    unique case (state_d)
      S_INIT: begin
        d1_d = 1'b1;
        d2_d = 1'b1;
        sr_d = 1'b1;
      end
      S_RUN, S_DRAIN: begin
        d1_d = act_w;
        d2_d = 1'b1;
      end
      S_HOLD:  hk_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge nclk) begin
    if (!sreset_b) begin
      state_q     <= S_IDLE;
      init_cnt_q  <= 4'd0;
      drain_cnt_q <= 4'd0;
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      sr_q        <= 1'b0;
      hk_q        <= 1'b0;
      dn_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      sr_q        <= sr_d;
      hk_q        <= hk_d;
      dn_q        <= dn_d;
    end
  end

  assign d1clk       = d1_q;
  assign d2clk       = d2_q;
  assign lclk_sreset = sr_q;
  assign hold_ack    = hk_q;
  assign init_done   = dn_q;

endmodule
